// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the
//               16-bit processor. Optional macro MULTICYCLE_CTRL_TRAP_EN
//               traps reserved opcodes instead of executing them as NOPs.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int OP_W = 4,
    parameter int ST_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic [ST_W-1:0] state,
    output logic            pc_we,
    output logic [1:0]      pc_src,
    output logic            ir_we,
    output logic            mem_req,
    output logic            mem_we,
    output logic            iord,
    output logic [1:0]      alu_src_b,
    output logic            alu_func_sel,
    output logic            reg_we,
    output logic [1:0]      wb_sel,
    output logic            instr_done,
    output logic            trap
);

    typedef enum logic [ST_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [OP_W-1:0] c_OP_RTYPE = OP_W'(0);
    localparam logic [OP_W-1:0] c_OP_LI    = OP_W'(6);
    localparam logic [OP_W-1:0] c_OP_JMP   = OP_W'(9);
    localparam logic [OP_W-1:0] c_OP_LD    = OP_W'(10);
    localparam logic [OP_W-1:0] c_OP_ST    = OP_W'(11);
    localparam logic [OP_W-1:0] c_OP_BEQ   = OP_W'(12);
    localparam logic [OP_W-1:0] c_OP_BNE   = OP_W'(13);
    localparam logic [OP_W-1:0] c_OP_RSV   = OP_W'(14);

    state_t          r_state;
    logic [OP_W-1:0] r_op_q;

    state_t          w_next;
    logic            w_pc_we;
    logic [1:0]      w_pc_src;
    logic            w_ir_we;
    logic            w_mem_req;
    logic            w_mem_we;
    logic            w_iord;
    logic [1:0]      w_alu_src_b;
    logic            w_alu_func_sel;
    logic            w_reg_we;
    logic [1:0]      w_wb_sel;
    logic            w_instr_done;
    logic            w_trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_op_q  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op_q <= op;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_pc_we        = 1'b0;
        w_pc_src       = 2'd0;
        w_ir_we        = 1'b0;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_iord         = 1'b0;
        w_alu_src_b    = 2'd0;
        w_alu_func_sel = 1'b0;
        w_reg_we       = 1'b0;
        w_wb_sel       = 2'd0;
        w_instr_done   = 1'b0;
        w_trap         = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            // op_q is only loaded at the end of this cycle, so decode from the live opcode
            S_DECODE: begin
                if (op == c_OP_JMP) begin
                    w_pc_we      = 1'b1;
                    w_pc_src     = 2'd2;
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end else if (op >= c_OP_RSV) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    w_next       = S_TRAP;
`else
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
`endif
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_alu_func_sel = (r_op_q == c_OP_RTYPE);
                case (r_op_q)
                    OP_W'(0), OP_W'(3), OP_W'(4):           w_alu_src_b = 2'd0;
                    OP_W'(1), OP_W'(2):                     w_alu_src_b = 2'd1;
                    OP_W'(5), OP_W'(6), OP_W'(7), OP_W'(8),
                    OP_W'(10), OP_W'(11), OP_W'(12),
                    OP_W'(13):                              w_alu_src_b = 2'd2;
                    default:                                w_alu_src_b = 2'd0;
                endcase
                if (r_op_q == c_OP_LD || r_op_q == c_OP_ST) begin
                    w_next = S_MEM;
                end else if (r_op_q == c_OP_BEQ || r_op_q == c_OP_BNE) begin
                    w_pc_we      = (r_op_q == c_OP_BEQ) ? zero : ~zero;
                    w_pc_src     = 2'd1;
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mem_we  = (r_op_q == c_OP_ST);
                if (mem_ready) begin
                    if (r_op_q == c_OP_ST) begin
                        w_instr_done = 1'b1;
                        w_next       = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_reg_we     = 1'b1;
                w_wb_sel     = (r_op_q == c_OP_LD) ? 2'd1 :
                               (r_op_q == c_OP_LI) ? 2'd2 : 2'd0;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_TRAP: begin
                w_trap = 1'b1;
                w_next = S_TRAP;
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held, not just after the state clears
    assign state        = rst_n ? r_state : '0;
    assign pc_we        = rst_n & w_pc_we;
    assign pc_src       = rst_n ? w_pc_src : 2'd0;
    assign ir_we        = rst_n & w_ir_we;
    assign mem_req      = rst_n & w_mem_req;
    assign mem_we       = rst_n & w_mem_we;
    assign iord         = rst_n & w_iord;
    assign alu_src_b    = rst_n ? w_alu_src_b : 2'd0;
    assign alu_func_sel = rst_n & w_alu_func_sel;
    assign reg_we       = rst_n & w_reg_we;
    assign wb_sel       = rst_n ? w_wb_sel : 2'd0;
    assign instr_done   = rst_n & w_instr_done;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign trap         = rst_n & w_trap;
`else
    assign trap         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Scoreboard bench for multicycle_ctrl with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] op;
    logic       zero;
    logic       mem_ready;
    logic [2:0] state;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic [1:0] alu_src_b;
    logic       alu_func_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       instr_done;
    logic       trap;

    multicycle_ctrl #(.OP_W(4), .ST_W(3)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .state        (state),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .ir_we        (ir_we),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .iord         (iord),
        .alu_src_b    (alu_src_b),
        .alu_func_sel (alu_func_sel),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .instr_done   (instr_done),
        .trap         (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [17:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    // {state, pc_we, pc_src, ir_we, mem_req, mem_we, iord, alu_src_b, alu_func_sel, reg_we, wb_sel, instr_done, trap}
    function automatic logic [17:0] v(input logic [2:0] st, input logic pcwe, input logic [1:0] pcs,
                                      input logic irwe, input logic mreq, input logic mwe, input logic io,
                                      input logic [1:0] asb, input logic afs, input logic rwe,
                                      input logic [1:0] wbs, input logic dn);
        return {st, pcwe, pcs, irwe, mreq, mwe, io, asb, afs, rwe, wbs, dn, 1'b0};
    endfunction

    function automatic logic [17:0] act();
        return {state, pc_we, pc_src, ir_we, mem_req, mem_we, iord, alu_src_b,
                alu_func_sel, reg_we, wb_sel, instr_done, trap};
    endfunction

    task automatic check(input string nm, input logic [17:0] got, input logic [17:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.nm, act(), e.v);
        end
    end

    // Drive one cycle's inputs, record its expected outputs, advance to just past the next edge
    task automatic cyc(input string nm, input logic [3:0] o, input logic z, input logic mr,
                       input logic [17:0] e);
        exp_t x;
        op        = o;
        zero      = z;
        mem_ready = mr;
        x.nm      = nm;
        x.v       = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    localparam logic [17:0] c_FETCH_OK   = 18'b000_1_00_1_1_0_0_00_0_0_00_0_0;
    localparam logic [17:0] c_FETCH_WAIT = 18'b000_0_00_0_1_0_0_00_0_0_00_0_0;
    localparam logic [17:0] c_DECODE     = 18'b001_0_00_0_0_0_0_00_0_0_00_0_0;
    localparam logic [17:0] c_ZERO       = 18'd0;

    task automatic alu_instr(input string nm, input logic [3:0] o, input logic [1:0] asb,
                             input logic afs, input logic [1:0] wbs);
        cyc({nm, "_fetch"}, 4'hF, 1'b0, 1'b1, c_FETCH_OK);
        cyc({nm, "_decode"}, o, 1'b0, 1'b1, c_DECODE);
        cyc({nm, "_exec"}, 4'hE, 1'b0, 1'b1, v(3'd2, 0, 2'd0, 0, 0, 0, 0, asb, afs, 0, 2'd0, 0));
        cyc({nm, "_wb"}, 4'hE, 1'b0, 1'b1, v(3'd4, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 1, wbs, 1));
    endtask

    task automatic branch_instr(input string nm, input logic [3:0] o, input logic z, input logic take);
        cyc({nm, "_fetch"}, 4'h0, 1'b0, 1'b1, c_FETCH_OK);
        cyc({nm, "_decode"}, o, 1'b0, 1'b1, c_DECODE);
        cyc({nm, "_exec"}, 4'h0, z, 1'b1, v(3'd2, take, 2'd1, 0, 0, 0, 0, 2'd2, 0, 0, 2'd0, 1));
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        op        = 4'h0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #2;
        check("reset_outputs", act(), c_ZERO);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // R-type, then async reset in the middle of EXEC
        cyc("rst_fetch", 4'h0, 1'b0, 1'b1, c_FETCH_OK);
        cyc("rst_decode", 4'h0, 1'b0, 1'b1, c_DECODE);
        begin
            exp_t x;
            x.nm = "rst_exec";
            x.v  = v(3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0);
            sb.push_back(x);
        end
        @(negedge clk);
        #1;
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("async_reset_zero", act(), c_ZERO);
        #1;
        rst_n = 1'b1;
        #1;
        check("after_release_fetch", act(), c_FETCH_WAIT);
        @(posedge clk);
        #1;

        // fetch wait states, then normal R-type
        cyc("fetch_wait0", 4'h0, 1'b0, 1'b0, c_FETCH_WAIT);
        cyc("fetch_wait1", 4'h0, 1'b0, 1'b0, c_FETCH_WAIT);
        cyc("fetch_done", 4'h0, 1'b0, 1'b1, c_FETCH_OK);
        cyc("r0_decode", 4'h0, 1'b0, 1'b1, c_DECODE);
        cyc("r0_exec", 4'h7, 1'b0, 1'b1, v(3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0));
        cyc("r0_wb", 4'h7, 1'b0, 1'b1, v(3'd4, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 1, 2'd0, 1));

        alu_instr("op1", 4'd1, 2'd1, 1'b0, 2'd0);
        alu_instr("op3", 4'd3, 2'd0, 1'b0, 2'd0);
        alu_instr("op5", 4'd5, 2'd2, 1'b0, 2'd0);
        alu_instr("op8", 4'd8, 2'd2, 1'b0, 2'd0);
        alu_instr("li", 4'd6, 2'd2, 1'b0, 2'd2);

        // load with three memory wait cycles
        cyc("ld_fetch", 4'h0, 1'b0, 1'b1, c_FETCH_OK);
        cyc("ld_decode", 4'd10, 1'b0, 1'b1, c_DECODE);
        cyc("ld_exec", 4'h0, 1'b0, 1'b1, v(3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd2, 0, 0, 2'd0, 0));
        for (int i = 0; i < 3; i++)
            cyc("ld_mem_wait", 4'h0, 1'b0, 1'b0, v(3'd3, 0, 2'd0, 0, 1, 0, 1, 2'd0, 0, 0, 2'd0, 0));
        cyc("ld_mem_done", 4'h0, 1'b0, 1'b1, v(3'd3, 0, 2'd0, 0, 1, 0, 1, 2'd0, 0, 0, 2'd0, 0));
        cyc("ld_wb", 4'h0, 1'b0, 1'b1, v(3'd4, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 1, 2'd1, 1));

        // store
        cyc("st_fetch", 4'h0, 1'b0, 1'b1, c_FETCH_OK);
        cyc("st_decode", 4'd11, 1'b0, 1'b1, c_DECODE);
        cyc("st_exec", 4'h0, 1'b0, 1'b1, v(3'd2, 0, 2'd0, 0, 0, 0, 0, 2'd2, 0, 0, 2'd0, 0));
        cyc("st_mem", 4'h0, 1'b0, 1'b1, v(3'd3, 0, 2'd0, 0, 1, 1, 1, 2'd0, 0, 0, 2'd0, 1));

        branch_instr("beq_taken", 4'd12, 1'b1, 1'b1);
        branch_instr("beq_not", 4'd12, 1'b0, 1'b0);
        branch_instr("bne_not", 4'd13, 1'b1, 1'b0);
        branch_instr("bne_taken", 4'd13, 1'b0, 1'b1);

        // jump and reserved-opcode NOP, both 2 cycles
        cyc("jmp_fetch", 4'h0, 1'b0, 1'b1, c_FETCH_OK);
        cyc("jmp_decode", 4'd9, 1'b0, 1'b1, v(3'd1, 1, 2'd2, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 1));
        cyc("nop_fetch", 4'h0, 1'b0, 1'b1, c_FETCH_OK);
        cyc("nop_decode", 4'd15, 1'b0, 1'b1, v(3'd1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 1));
        cyc("post_nop_fetch", 4'h0, 1'b0, 1'b1, c_FETCH_OK);

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
